bus_rr_arbiter: RTL and testbench
=================================

# bus_rr_arbiter

Parametrised packet bus between `DRIVERS` devices: each device pushes packets into its own input FIFO; a round-robin arbiter moves at most one packet per cycle from an input FIFO head to the destination's output register (or to every other device for broadcast). It replaces the fixed two-driver, software-FIFO bus model with synthesizable buffering, configurable depth/width/channel count, broadcast, drop accounting and overflow flags. It sits between the driver agents and the per-device receive logic.

## Interface
- `DRIVERS`, 4: number of devices (2..16).
- `PCKG`, 32: packet width in bits (>= 16).
- `DEPTH`, 8: entries per input FIFO (power of 2, >= 2).
- `BROD`, 8'hFF: broadcast ID value.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `push`  in  DRIVERS  per-device write strobe.
- `D_push`  in  DRIVERS x PCKG  per-device write data; bits [PCKG-1:PCKG-8] are the destination ID.
- `full`  out  DRIVERS  input FIFO i holds DEPTH entries.
- `ovf`  out  DRIVERS  sticky: a push was dropped because FIFO i was full.
- `pndng`  out  DRIVERS  output register j holds a valid packet.
- `D_pop`  out  DRIVERS x PCKG  output packet for device j; unchanged while `pndng[j]` is high and `pop[j]` is low.
- `pop`  in  DRIVERS  device j accepts `D_pop[j]` this cycle; ignored when `pndng[j]` is low.
- `drop_cnt`  out  16  saturating count of packets discarded for an invalid destination ID.

## Operation
- Input FIFO i: `push[i]` with `!full[i]` writes `D_push[i]`. A push while full is discarded and sets `ovf[i]`. A simultaneous pop and push on a full FIFO accepts both; occupancy is unchanged.
- Output slot j is free when `!pndng[j] || pop[j]`.
- Head of FIFO i is deliverable when:
  - ID < DRIVERS and slot ID is free (a self-addressed packet is legal), or
  - ID == BROD and every slot j != i is free.
- Invalid head (ID >= DRIVERS and != BROD) is always eligible; when granted it is popped, no slot is loaded, and `drop_cnt` increments, saturating at 16'hFFFF.
- Arbiter: among non-empty FIFOs with an eligible head, grant the first index after `last_grant` (wrapping modulo DRIVERS). `last_grant` updates only on a grant. Non-eligible heads are skipped that cycle without blocking the others.
- On grant: pop FIFO i; load the packet into slot ID, or into every slot except i for broadcast; set the corresponding `pndng` bits.
- A slot popped without a reload clears `pndng[j]` at the same edge. Pop and reload in the same cycle keep `pndng[j]` high and carry the new data.
- At most one grant per cycle.

## Timing
- Reset (asynchronous, active-low) clears:
  - all FIFO pointers and counts;
  - `full` = 0, `ovf` = 0, `pndng` = 0, `D_pop` = 0, `drop_cnt` = 0;
  - `last_grant` = DRIVERS-1, so index 0 wins first.
- Reset mid-operation discards all buffered packets. No output glitches after deassertion.
- Latency: push sampled at edge E into an empty FIFO, uncontended → `pndng` rises after edge E+1. No same-cycle bypass.
- `full` and `ovf` are registered and update at the edge that changes the occupancy.
- Throughput: one packet per cycle across the whole bus. Each FIFO sustains one push and one pop per cycle.
- `pop[j]` to slot-free is combinational (same-cycle reload); there is no combinational path from `push` to any output.

## Structure
- Package `bus_pkg`:
  - `ID_W` = 8;
  - packet-ID extraction function;
  - grant-state typedef;
  - `DROP_CNT_W` = 16.
- Sub-module `bus_sync_fifo` (params WIDTH, DEPTH): push/pop/full/empty/count with wrap-around pointers and an extra MSB for full/empty disambiguation, instantiated DRIVERS times.
- The top level holds the arbiter, eligibility logic, output slots and counters.

## Test plan
- Reset, then device 0 pushes 32'h0100_0017 (ID 1) with `pop[1]` held high → `pndng[1]` high two edges after the push with `D_pop[1]` = 32'h0100_0017, all other `pndng` low.
- All four devices push to ID 2 every cycle, `pop[2]` = 1 → deliveries arrive in source order 0,1,2,3,0,… with no source skipped.
- Device 3 pushes ID 8'hFF while all slots are free → `pndng` = 4'b0111 with identical data. Repeat with `pop[1]` = 0 and slot 1 occupied → broadcast held until slot 1 frees.
- Push 9 packets into FIFO 0 (DEPTH 8) with slot 1 blocked → `full[0]` rises after the 8th push, the 9th is dropped, `ovf[0]` = 1 until reset.
- Push ID 8'h05 with DRIVERS = 4 → no `pndng` change, FIFO empties, `drop_cnt` = 1.
- Assert `reset` low while 3 packets are queued and 2 slots are pending → all outputs return to their reset values immediately; after release the first new push is delivered normally.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared constants, packet-ID helper and grant classification for the packet bus.
package bus_pkg;

  localparam int ID_W       = 8;
  localparam int DROP_CNT_W = 16;
  localparam int MAX_PCKG   = 256;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_UNI,
    GNT_BCAST,
    GNT_DROP
  } grant_kind_e;

  // Destination ID lives in the top ID_W bits of a pckg-wide packet.
  function automatic logic [ID_W-1:0] pkt_id(input logic [MAX_PCKG-1:0] pkt, input int pckg);
    return ID_W'(pkt >> (pckg - ID_W));
  endfunction

endpackage

// File: rtl/bus_sync_fifo.sv
// Synchronous FIFO with wrap-around pointers; the extra pointer MSB separates full from empty.
module bus_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
  assign count = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];

  // A pop frees the entry this cycle, so a push into a full FIFO is still taken.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Packet bus: per-device input FIFOs, round-robin arbiter, per-device output slots,
// broadcast delivery and drop accounting for invalid destinations.
module bus_rr_arbiter
  import bus_pkg::*;
#(
  parameter int              DRIVERS = 4,
  parameter int              PCKG    = 32,
  parameter int              DEPTH   = 8,
  parameter logic [ID_W-1:0] BROD    = 8'hFF
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [DRIVERS-1:0]                push,
  input  logic [DRIVERS-1:0][PCKG-1:0]      D_push,
  output logic [DRIVERS-1:0]                full,
  output logic [DRIVERS-1:0]                ovf,
  output logic [DRIVERS-1:0]                pndng,
  output logic [DRIVERS-1:0][PCKG-1:0]      D_pop,
  input  logic [DRIVERS-1:0]                pop,
  output logic [DROP_CNT_W-1:0]             drop_cnt
);

  localparam int              LG_W   = $clog2(DRIVERS);
  localparam int              CNT_W  = $clog2(DEPTH) + 1;
  localparam logic [ID_W-1:0] DRV_ID = ID_W'(DRIVERS);

  logic [DRIVERS-1:0]             fifo_full;
  logic [DRIVERS-1:0]             fifo_empty;
  logic [DRIVERS-1:0]             fifo_pop;
  logic [DRIVERS-1:0][CNT_W-1:0]  fifo_count;
  logic [DRIVERS-1:0][PCKG-1:0]   head;
  logic [DRIVERS-1:0][ID_W-1:0]   head_id;

  logic [DRIVERS-1:0]             slot_free;
  logic [DRIVERS-1:0]             eligible;
  logic [DRIVERS-1:0]             load;
  logic [LG_W-1:0]                last_grant;
  logic                           gnt_valid;
  logic [LG_W-1:0]                gnt_idx;
  logic [ID_W-1:0]                gnt_id;
  logic [PCKG-1:0]                gnt_pkt;
  grant_kind_e                    gnt_kind;

  for (genvar i = 0; i < DRIVERS; i++) begin : g_fifo
    bus_sync_fifo #(
      .WIDTH (PCKG),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push[i]),
      .pop   (fifo_pop[i]),
      .wdata (D_push[i]),
      .rdata (head[i]),
      .full  (fifo_full[i]),
      .empty (fifo_empty[i]),
      .count (fifo_count[i])
    );
    assign full[i]    = (fifo_count[i] == CNT_W'(DEPTH));
    assign head_id[i] = pkt_id(MAX_PCKG'(head[i]), PCKG);
  end

  // Popping a slot frees it in the same cycle, allowing a back-to-back reload.
  assign slot_free = ~pndng | pop;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < DRIVERS; i++) begin
      if (!fifo_empty[i]) begin
        if (head_id[i] < DRV_ID)
          eligible[i] = slot_free[head_id[i][LG_W-1:0]];
        else if (head_id[i] == BROD)
          eligible[i] = &(slot_free | (DRIVERS'(1) << i));
        else
          eligible[i] = 1'b1;
      end
    end
  end

  always_comb begin
    int cand;
    cand      = 0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = 1; k <= DRIVERS; k++) begin
      cand = int'(last_grant) + k;
      if (cand >= DRIVERS) cand = cand - DRIVERS;
      if (!gnt_valid && eligible[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = LG_W'(cand);
      end
    end
  end

  always_comb begin
    gnt_id   = head_id[gnt_idx];
    gnt_pkt  = head[gnt_idx];
    gnt_kind = GNT_NONE;
    fifo_pop = '0;
    load     = '0;
    if (gnt_valid) begin
      fifo_pop = DRIVERS'(1) << gnt_idx;
      if (gnt_id < DRV_ID) begin
        gnt_kind = GNT_UNI;
        load     = DRIVERS'(1) << gnt_id[LG_W-1:0];
      end else if (gnt_id == BROD) begin
        gnt_kind = GNT_BCAST;
        load     = ~(DRIVERS'(1) << gnt_idx);
      end else begin
        gnt_kind = GNT_DROP;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pndng <= '0;
      D_pop <= '0;
    end else begin
      for (int j = 0; j < DRIVERS; j++) begin
        if (load[j]) begin
          pndng[j] <= 1'b1;
          D_pop[j] <= gnt_pkt;
        end else if (pop[j]) begin
          pndng[j] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= LG_W'(DRIVERS - 1);
      ovf        <= '0;
      drop_cnt   <= '0;
    end else begin
      if (gnt_valid) last_grant <= gnt_idx;
      ovf <= ovf | (push & fifo_full & ~fifo_pop);
      if (gnt_kind == GNT_DROP && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter (DRIVERS=4, PCKG=32, DEPTH=8).
module tb_bus_rr_arbiter;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       push;
  logic [3:0]       pop;
  logic [3:0][31:0] d_push;
  logic [3:0]       full;
  logic [3:0]       ovf;
  logic [3:0]       pndng;
  logic [3:0][31:0] d_pop;
  logic [15:0]      drop_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bus_rr_arbiter #(
    .DRIVERS (4),
    .PCKG    (32),
    .DEPTH   (8),
    .BROD    (8'hFF)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .D_push   (d_push),
    .full     (full),
    .ovf      (ovf),
    .pndng    (pndng),
    .D_pop    (d_pop),
    .pop      (pop),
    .drop_cnt (drop_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    push   = '0;
    pop    = '0;
    d_push = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    reset  = 1'b0;
    push   = '0;
    pop    = '0;
    d_push = '0;
    #1;
    check("rst_pndng", pndng, 4'b0000);
    check("rst_full", full, 4'b0000);
    check("rst_ovf", ovf, 4'b0000);
    check("rst_drop", drop_cnt, 16'h0000);
    check("rst_dpop", d_pop[1], 32'h0);

    // Single unicast, latency and pop-clear
    do_reset();
    push[0]   = 1'b1;
    d_push[0] = 32'h0100_0017;
    pop[1]    = 1'b1;
    tick();
    push = '0;
    check("lat_no_bypass", pndng, 4'b0000);
    tick();
    check("uni_pndng", pndng, 4'b0010);
    check("uni_data", d_pop[1], 32'h0100_0017);
    tick();
    check("uni_pop_clear", pndng, 4'b0000);

    // Round-robin fairness: all sources to slot 2
    do_reset();
    pop  = 4'b0100;
    push = 4'hF;
    for (int s = 0; s < 4; s++) d_push[s] = {8'h02, 8'h00, 8'(s), 8'h00};
    tick();
    for (int s = 0; s < 4; s++) d_push[s] = {8'h02, 8'h00, 8'(s), 8'h01};
    tick();
    push = '0;
    for (int n = 0; n < 8; n++) begin
      if (n > 0) tick();
      check("rr_order", d_pop[2], {8'h02, 8'h00, 8'(n % 4), 8'(n / 4)});
      check("rr_pndng", pndng, 4'b0100);
    end
    tick();
    check("rr_drained", pndng, 4'b0000);

    // Broadcast, then broadcast held by a busy slot
    do_reset();
    push[3]   = 1'b1;
    d_push[3] = 32'hFF00_00AB;
    tick();
    push = '0;
    tick();
    check("bc_pndng", pndng, 4'b0111);
    check("bc_d0", d_pop[0], 32'hFF00_00AB);
    check("bc_d1", d_pop[1], 32'hFF00_00AB);
    check("bc_d2", d_pop[2], 32'hFF00_00AB);
    check("bc_d3", d_pop[3], 32'h0);
    pop       = 4'b0101;
    push[3]   = 1'b1;
    d_push[3] = 32'hFF00_00CD;
    tick();
    push = '0;
    pop  = '0;
    check("bc_partial_pop", pndng, 4'b0010);
    tick();
    check("bc_held", pndng, 4'b0010);
    check("bc_held_d1", d_pop[1], 32'hFF00_00AB);
    tick();
    check("bc_held2", pndng, 4'b0010);
    pop = 4'b0010;
    tick();
    pop = '0;
    check("bc2_pndng", pndng, 4'b0111);
    check("bc2_d0", d_pop[0], 32'hFF00_00CD);
    check("bc2_d1", d_pop[1], 32'hFF00_00CD);
    check("bc2_d2", d_pop[2], 32'hFF00_00CD);

    // FIFO full / overflow with slot 1 blocked
    do_reset();
    push[1]   = 1'b1;
    d_push[1] = 32'h0100_0EEE;
    tick();
    push = '0;
    tick();
    check("blk_pndng", pndng, 4'b0010);
    for (int k = 0; k < 9; k++) begin
      push[0]   = 1'b1;
      d_push[0] = 32'h0100_0000 | k;
      tick();
      if (k == 6) check("full_7th", full, 4'b0000);
      if (k == 7) begin
        check("full_8th", full, 4'b0001);
        check("ovf_8th", ovf, 4'b0000);
      end
      if (k == 8) begin
        check("full_9th", full, 4'b0001);
        check("ovf_9th", ovf, 4'b0001);
      end
    end
    push = '0;
    pop  = 4'b0010;
    tick();
    check("drain_full", full, 4'b0000);
    check("drain_first", d_pop[1], 32'h0100_0000);
    repeat (7) tick();
    check("drain_last", d_pop[1], 32'h0100_0007);
    check("drain_last_pndng", pndng, 4'b0010);
    tick();
    check("ninth_dropped", pndng, 4'b0000);
    check("ovf_sticky", ovf, 4'b0001);
    pop = '0;

    // Invalid destination
    do_reset();
    push[0]   = 1'b1;
    d_push[0] = 32'h0500_0001;
    tick();
    push = '0;
    check("drop_before", drop_cnt, 16'd0);
    tick();
    check("drop_cnt", drop_cnt, 16'd1);
    check("drop_pndng", pndng, 4'b0000);
    tick();
    check("drop_once", drop_cnt, 16'd1);

    // Reset while traffic is queued and slots pending
    do_reset();
    push      = 4'b0111;
    d_push[0] = 32'h0100_0010;
    d_push[1] = 32'h0200_0011;
    d_push[2] = 32'h0100_0020;
    tick();
    push      = 4'b0100;
    d_push[2] = 32'h0100_0021;
    tick();
    d_push[2] = 32'h0100_0022;
    tick();
    push = '0;
    tick();
    check("pre_rst_pndng", pndng, 4'b0110);
    check("pre_rst_d2", d_pop[2], 32'h0200_0011);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_pndng", pndng, 4'b0000);
    check("mid_rst_d1", d_pop[1], 32'h0);
    check("mid_rst_d2", d_pop[2], 32'h0);
    check("mid_rst_full", full, 4'b0000);
    @(negedge clk);
    reset = 1'b1;
    tick();
    push[3]   = 1'b1;
    d_push[3] = 32'h0000_0033;
    tick();
    push = '0;
    tick();
    check("post_rst_pndng", pndng, 4'b0001);
    check("post_rst_data", d_pop[0], 32'h0000_0033);
    tick();
    check("post_rst_no_stale", pndng, 4'b0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
